// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Contents: requester (owner) encoding, arbiter FSM state encoding and the
// RISC-V load/store funct3 size codes presented on the memory port.
package unified_mem_arbiter_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StRdWait = 1'b1
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle around the memory arbiter: fetch request port, data load/store
// port, the single physical memory port and the busy flag.
// Modports:
//   slave  - the arbiter's view (takes requests and mem_rdata, drives
//            grants, read data, mem_* strobes and busy)
//   master - the surrounding pipeline/memory view (the mirror image)
interface unified_mem_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
);
    // fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_funct3;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3, busy
    );

endinterface

// File: rtl/unified_mem_arbiter_mem_prio_picker.sv
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   if_req   - fetch request, already qualified by "grant possible"
//   d_req    - data request, already qualified by "grant possible"
//   starved  - fetch has lost STARVE_MAX consecutive cycles
//   pick_if  - fetch wins this cycle
//   pick_d   - data wins this cycle
// At most one of pick_if/pick_d is high.
module mem_prio_picker (
    input  logic if_req,
    input  logic d_req,
    input  logic starved,
    output logic pick_if,
    output logic pick_d
);

    always_comb begin
        // Data normally wins; a starved fetch overrides it.
        pick_d  = d_req && !(starved && if_req);
        pick_if = if_req && !pick_d;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single unified instruction/data memory. Grants one of the
// fetch or data requesters per cycle, drives the memory port combinationally
// in the grant cycle, tracks the one outstanding read and returns its data as
// a one-cycle rvalid pulse to the requester that issued it.
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset
//   bus  - request/grant/read-data and memory port bundle (slave view)
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 12,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);

    localparam int unsigned LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_LAST   = LW'(RD_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;

    logic rd_done;
    logic gnt_ok;
    logic starved;
    logic pick_if;
    logic pick_d;
    logic new_read;

    // Completion cycle of the outstanding read; a new grant may overlap it.
    assign rd_done  = (state_q == StRdWait) && (lat_q == LAT_LAST) && !rst;
    assign gnt_ok   = !rst && ((state_q == StIdle) || rd_done);
    assign starved  = (starve_q == STARVE_TOP);
    assign new_read = pick_if || (pick_d && !bus.d_we);

    mem_prio_picker u_picker (
        .if_req  (bus.if_req && gnt_ok),
        .d_req   (bus.d_req && gnt_ok),
        .starved (starved),
        .pick_if (pick_if),
        .pick_d  (pick_d)
    );

    // Grants, read return and the memory port.
    always_comb begin
        bus.if_gnt     = pick_if;
        bus.d_gnt      = pick_d;
        bus.if_rvalid  = rd_done && (owner_q == OWN_IF);
        bus.d_rvalid   = rd_done && (owner_q == OWN_D);
        bus.if_rdata   = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata    = bus.d_rvalid ? bus.mem_rdata : '0;
        bus.busy       = (state_q == StRdWait) && !rst;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = 3'b000;
        if (pick_d) begin
            bus.mem_en     = 1'b1;
            bus.mem_we     = bus.d_we;
            bus.mem_addr   = bus.d_addr;
            bus.mem_wdata  = bus.d_wdata;
            bus.mem_funct3 = bus.d_funct3;
        end else if (pick_if) begin
            bus.mem_en     = 1'b1;
            bus.mem_addr   = bus.if_addr;
            bus.mem_funct3 = F3_LW;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        lat_d    = lat_q;
        starve_d = starve_q;

        if (state_q == StRdWait) begin
            if (lat_q == LAT_LAST) begin
                state_d = StIdle;
                lat_d   = '0;
            end else begin
                lat_d = lat_q + 1'b1;
            end
        end

        if (new_read) begin
            state_d = StRdWait;
            owner_d = pick_if ? OWN_IF : OWN_D;
            lat_d   = '0;
        end

        // Counts every cycle a fetch waits, including cycles blocked by a read.
        if (!bus.if_req || pick_if) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= OWN_IF;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end

endmodule
